// File: rtl/arb_mux_if.sv
// Handshake bundle for arb_mux: N request channels in, one registered word out.
// The master side drives requests and downstream ready; the slave side is the arbiter.
interface arb_mux_if #(
  parameter int WIDTH = 4,
  parameter int N     = 4
);
  localparam int SW = $clog2(N);

  logic                      mode;
  logic [N-1:0]              in_valid;
  logic [N-1:0][WIDTH-1:0]   in_data;
  logic [N-1:0]              in_ready;
  logic                      out_valid;
  logic [WIDTH-1:0]          out_data;
  logic [SW-1:0]             out_sel;
  logic                      out_ready;

  modport master (
    output mode, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_sel
  );

  modport slave (
    input  mode, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_sel
  );
endinterface

// File: rtl/arb_mux.sv
// N-channel arbiter (fixed priority or round-robin) feeding a single output register
// with one-word-per-cycle throughput under continuous draining.
module arb_mux_lane #(
  parameter int WIDTH = 4,
  parameter int SW    = 2,
  parameter int IDX   = 0
) (
  input  logic             vld,
  input  logic [SW-1:0]    ptr,
  input  logic             gnt,
  input  logic [WIDTH-1:0] data,
  output logic             hi,
  output logic [WIDTH-1:0] data_m
);
  // Requests at or above the round-robin pointer get the first look.
  assign hi     = vld && (SW'(IDX) >= ptr);
  // AND-OR mux so a non-granted lane's data (even X) never reaches the output.
  assign data_m = data & {WIDTH{gnt}};
endmodule

module arb_mux #(
  parameter int WIDTH = 4,
  parameter int N     = 4
) (
  input  logic      clk,
  input  logic      rst,
  arb_mux_if.slave  bus
);
  localparam int SW = $clog2(N);

  logic [N-1:0]            hi, req, gnt, gnt_q;
  logic [N-1:0][WIDTH-1:0] data_m;
  logic [WIDTH-1:0]        data_sel;
  logic [SW-1:0]           g, ptr;
  logic                    load_en, any;
  logic                    val_q;
  logic [WIDTH-1:0]        data_q;
  logic [SW-1:0]           sel_q;

  for (genvar i = 0; i < N; i++) begin : g_lane
    arb_mux_lane #(.WIDTH(WIDTH), .SW(SW), .IDX(i)) u_lane (
      .vld    (bus.in_valid[i]),
      .ptr    (ptr),
      .gnt    (gnt[i]),
      .data   (bus.in_data[i]),
      .hi     (hi[i]),
      .data_m (data_m[i])
    );
  end

  assign load_en = !val_q || bus.out_ready;
  assign any     = |bus.in_valid;

  // Round-robin: lowest request at/after ptr, else wrap to lowest overall.
  always_comb begin
    req = (bus.mode && (|hi)) ? hi : bus.in_valid;
    gnt = req & (~req + N'(1));
  end

  always_comb begin
    g        = '0;
    data_sel = '0;
    for (int i = 0; i < N; i++) begin
      if (gnt[i]) g = SW'(i);
      data_sel = data_sel | data_m[i];
    end
  end

  assign gnt_q        = (load_en && !rst) ? gnt : '0;
  assign bus.in_ready = gnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      val_q  <= 1'b0;
      data_q <= '0;
      sel_q  <= '0;
      ptr    <= '0;
    end else if (load_en) begin
      if (any) begin
        val_q  <= 1'b1;
        data_q <= data_sel;
        sel_q  <= g;
        if (bus.mode) ptr <= (g == SW'(N - 1)) ? '0 : g + 1'b1;
      end else begin
        // load_en with a held word means it is draining this cycle
        val_q <= 1'b0;
      end
    end
  end

  assign bus.out_valid = val_q;
  assign bus.out_data  = data_q;
  assign bus.out_sel   = sel_q;
endmodule

// File: tb/tb_arb_mux.sv
// Scoreboard bench for arb_mux: a reference arbiter predicts in_ready and the
// word each grant should produce; words are popped as the output drains.
module tb_arb_mux;
  localparam int WIDTH = 4;
  localparam int N     = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  arb_mux_if #(.WIDTH(WIDTH), .N(N)) bus ();
  arb_mux #(.WIDTH(WIDTH), .N(N)) dut (.clk(clk), .rst(rst), .bus(bus));

  int         n_chk = 0;
  int         n_fail = 0;
  int         m_ptr = 0;
  logic       m_valid = 1'b0;
  logic [7:0] q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] mgrant(input logic md, input logic [3:0] v, input int p);
    int idx;
    for (int k = 0; k < 4; k++) begin
      idx = md ? (p + k) % 4 : k;
      if (v[idx]) return 4'(1 << idx);
    end
    return 4'b0;
  endfunction

  // Called at posedge+1 with inputs already driven; returns at next posedge+1.
  task automatic cycle();
    logic [3:0] g;
    logic       le;
    int         gi;
    logic [7:0] w;
    @(negedge clk);
    le = !m_valid || bus.out_ready;
    g  = le ? mgrant(bus.mode, bus.in_valid, m_ptr) : 4'b0;
    chk("in_ready", bus.in_ready, g);
    chk("out_valid", bus.out_valid, m_valid);
    if (m_valid) chk("sb_depth", q.size(), 1);
    if (m_valid && bus.out_ready && q.size() > 0) begin
      w = q.pop_front();
      chk("sb_data", bus.out_data, w[3:0]);
      chk("sb_sel", bus.out_sel, w[5:4]);
    end
    gi = -1;
    for (int k = 0; k < 4; k++) if (g[k]) gi = k;
    if (gi >= 0) begin
      q.push_back({2'b00, 2'(gi), bus.in_data[gi]});
      m_valid = 1'b1;
      if (bus.mode) m_ptr = (gi + 1) % 4;
    end else if (le) begin
      m_valid = 1'b0;
    end
    @(posedge clk); #1;
  endtask

  task automatic rand_data();
    for (int c = 0; c < N; c++) bus.in_data[c] = 4'($urandom);
  endtask

  int seq[6] = '{0, 1, 2, 3, 0, 1};
  logic [7:0] held;

  initial begin
    bus.mode      = 1'b0;
    bus.in_valid  = 4'b1111;
    bus.out_ready = 1'b1;
    rand_data();

    // reset holds everything quiet regardless of requests
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("rst_out_valid", bus.out_valid, 0);
      chk("rst_out_data", bus.out_data, 0);
      chk("rst_out_sel", bus.out_sel, 0);
      chk("rst_in_ready", bus.in_ready, 0);
    end
    bus.in_valid = 4'b0;
    rst = 1'b0;
    @(posedge clk); #1;

    // fixed priority, X on non-granted lanes
    bus.mode     = 1'b0;
    bus.in_valid = 4'b1010;
    bus.in_data  = {4'hC, 4'hx, 4'h5, 4'hx};
    cycle();
    chk("fp_out_data", bus.out_data, 4'h5);
    chk("fp_out_sel", bus.out_sel, 1);

    // drain
    bus.in_valid = 4'b0;
    rand_data();
    cycle();
    chk("drain_valid", bus.out_valid, 0);
    chk("drain_data_hold", bus.out_data, 4'h5);

    // round-robin wrap
    bus.mode     = 1'b1;
    bus.in_valid = 4'b1111;
    for (int k = 0; k < 6; k++) begin
      rand_data();
      cycle();
      chk("rr_seq", bus.out_sel, seq[k]);
    end

    // backpressure: hold a word while inputs churn
    bus.mode      = 1'b0;
    bus.out_ready = 1'b0;
    bus.in_valid  = 4'b0001;
    rand_data();
    cycle();
    held = q[0];
    for (int k = 0; k < 3; k++) begin
      bus.in_valid = 4'($urandom_range(1, 15));
      rand_data();
      cycle();
      chk("bp_data", bus.out_data, held[3:0]);
      chk("bp_sel", bus.out_sel, held[5:4]);
    end
    bus.out_ready = 1'b1;
    bus.in_valid  = 4'b0100;
    rand_data();
    cycle();
    chk("bp_nobubble_valid", bus.out_valid, 1);
    chk("bp_nobubble_sel", bus.out_sel, 2);

    // async reset mid-stream with a word held and ptr nonzero
    bus.out_ready = 1'b0;
    bus.mode      = 1'b1;
    bus.in_valid  = 4'b1111;
    #2 rst = 1'b1;
    #1;
    chk("arst_out_valid", bus.out_valid, 0);
    chk("arst_in_ready", bus.in_ready, 0);
    chk("arst_ptr", dut.ptr, 0);
    chk("arst_out_data", bus.out_data, 0);
    bus.in_valid = 4'b0;
    @(negedge clk);
    rst = 1'b0;
    m_valid = 1'b0;
    m_ptr   = 0;
    q.delete();
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    bus.in_valid  = 4'b1111;
    rand_data();
    cycle();
    chk("post_rst_rr_sel", bus.out_sel, 0);

    // random traffic
    for (int k = 0; k < 300; k++) begin
      bus.mode      = 1'($urandom);
      bus.in_valid  = 4'($urandom);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      rand_data();
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/arb_mux.md
ARB_MUX -- requirements
Module: arb_mux

Interface
REQ-001 SHALL have parameter WIDTH, default 4, data bits per channel (1..32).
REQ-002 SHALL have parameter N, default 4, number of input channels (2..16).
REQ-003 SHALL have derived localparam SW = $clog2(N), select/pointer width.
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 rst  input  1  reset, asynchronous and active-high.
REQ-006 mode  input  1  0 = fixed priority (lowest index wins); 1 = round-robin.
REQ-007 in_valid  input  N  per-channel request; bit i belongs to channel i.
REQ-008 in_data  input  N*WIDTH  channel i data in bits [i*WIDTH +: WIDTH].
REQ-009 in_ready  output  N  one-hot-or-zero grant; channel i transfer = in_valid[i] & in_ready[i].
REQ-010 out_valid  output  1  output register holds a word.
REQ-011 out_data  output  WIDTH  registered data word.
REQ-012 out_sel  output  SW  index of the channel that supplied out_data.
REQ-013 out_ready  input  1  downstream accepts; output transfer = out_valid & out_ready.

Function
REQ-014 SHALL define load_en = !out_valid | out_ready (output register free or being drained this cycle).
REQ-015 in_ready SHALL be combinational: at most one bit set, only when load_en=1 and that channel's in_valid=1.
REQ-016 mode=0: SHALL grant the lowest index i with in_valid[i]=1.
REQ-017 mode=1: SHALL grant the first valid index searching ptr, ptr+1, ..., wrapping N-1 -> 0.
REQ-018 On a grant to channel g, SHALL register out_data <= in_data[g], out_sel <= g, out_valid <= 1 at the next edge (latency 1 cycle).
REQ-019 On a grant in mode=1, SHALL update ptr <= (g == N-1) ? 0 : g+1; ptr SHALL NOT change in mode=0 or without a grant.
REQ-020 When load_en=1 and no in_valid bit is set, SHALL clear out_valid if an output transfer occurs and hold it otherwise; out_data/out_sel SHALL hold.
REQ-021 When out_valid=1 and out_ready=0, in_ready SHALL be all-zero and out_data/out_sel SHALL be stable.
REQ-022 Simultaneous output transfer and new grant in the same cycle SHALL sustain one word per cycle with no bubble.
REQ-023 A mode change SHALL take effect in the same cycle's arbitration; ptr SHALL be retained across mode changes.
REQ-024 SHALL not depend on in_data of non-granted channels; X on those SHALL not propagate.
REQ-025 SHALL contain no combinational path from out_ready to out_data or out_valid.

Reset
REQ-026 While rst=1: out_valid=0, out_data=0, out_sel=0, ptr=0, in_ready=0, regardless of clk.
REQ-027 Reset asserted mid-operation SHALL discard the held word immediately; no transfer SHALL be reported for it.
REQ-028 On the first edge after rst deasserts, the block SHALL arbitrate normally.

Verification
REQ-029 Reset: drive rst=1 with in_valid=4'b1111, toggle clk -> out_valid=0, out_data=0, in_ready=0 throughout.
REQ-030 Fixed priority: mode=0, N=4, in_valid=4'b1010, in_data ch1=4'h5 ch3=4'hC, out_ready=1 -> in_ready=4'b0010, next cycle out_data=4'h5, out_sel=1.
REQ-031 Round-robin wrap: mode=1, all in_valid=1, out_ready=1 for 6 cycles -> out_sel sequence 0,1,2,3,0,1.
REQ-032 Backpressure: out_valid=1 with out_ready=0 for 3 cycles while inputs change -> in_ready=0, out_data/out_sel unchanged; on out_ready=1 new word loads next edge with no bubble.
REQ-033 Drain: single word held, in_valid=0, out_ready=1 -> out_valid=0 next cycle, out_data held.
REQ-034 Async reset mid-stream: assert rst between edges while out_valid=1 -> out_valid=0 immediately, ptr=0, next post-reset round-robin grant to channel 0.
